// File: rtl/wb_arbiter.sv
// Write-back arbiter: three result producers feed per-source FIFOs that a
// round-robin arbiter drains, one entry per cycle, into the registered register-file write port.
module wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     s0_valid,
    output logic                     s0_ready,
    input  logic [ADDRESS_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0]    s0_data,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [ADDRESS_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0]    s1_data,
    input  logic                     s2_valid,
    output logic                     s2_ready,
    input  logic [ADDRESS_WIDTH-1:0] s2_addr,
    input  logic [DATA_WIDTH-1:0]    s2_data,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD,
    output logic                     idle
);

    localparam int NSRC  = 3;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic                     src_valid [NSRC];
    logic [ADDRESS_WIDTH-1:0] src_addr  [NSRC];
    logic [DATA_WIDTH-1:0]    src_data  [NSRC];

    logic [CNT_W-1:0]         count  [NSRC];
    logic [PTR_W-1:0]         wr_ptr [NSRC];
    logic [PTR_W-1:0]         rd_ptr [NSRC];
    logic [ADDRESS_WIDTH-1:0] mem_addr [NSRC][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data [NSRC][FIFO_DEPTH];

    logic [NSRC-1:0]          full;
    logic [NSRC-1:0]          empty;
    logic [NSRC-1:0]          push;
    logic [NSRC-1:0]          grant;

    logic [1:0]               last;
    logic                     gnt_any;
    logic [1:0]               gnt_src;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;

    // Source n that follows cur by step positions in the 0,1,2 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] cur, input int step);
        int s;
        s = int'(cur) + step;
        if (s >= NSRC) s = s - NSRC;
        return s[1:0];
    endfunction

    assign src_valid[0] = s0_valid;
    assign src_valid[1] = s1_valid;
    assign src_valid[2] = s2_valid;
    assign src_addr[0]  = s0_addr;
    assign src_addr[1]  = s1_addr;
    assign src_addr[2]  = s2_addr;
    assign src_data[0]  = s0_data;
    assign src_data[1]  = s1_data;
    assign src_data[2]  = s2_data;

    // Ready depends only on the registered count, so a full FIFO that pops
    // this cycle still refuses the push.
    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        for (int n = 0; n < NSRC; n++) begin
            full[n]  = (count[n] == FULL_CNT);
            empty[n] = (count[n] == '0);
            push[n]  = src_valid[n] && !full[n] && (src_addr[n] != '0);
        end
    end

    assign s0_ready = !full[0];
    assign s1_ready = !full[1];
    assign s2_ready = !full[2];

    // FIFO control: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int n = 0; n < NSRC; n++) begin
                count[n]  <= '0;
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NSRC; n++) begin
                if (push[n])  wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
                if (grant[n]) rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
                case ({push[n], grant[n]})
                    2'b10:   count[n] <= count[n] + CNT_W'(1);
                    2'b01:   count[n] <= count[n] - CNT_W'(1);
                    default: count[n] <= count[n];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < NSRC; n++) begin
            if (push[n]) begin
                mem_addr[n][wr_ptr[n]] <= src_addr[n];
                mem_data[n][wr_ptr[n]] <= src_data[n];
            end
        end
    end

    // Round-robin scan starting just after the most recently granted source.
    always_comb begin
        gnt_any = 1'b0;
        gnt_src = last;
        grant   = '0;
        for (int k = 1; k <= NSRC; k++) begin
            if (!gnt_any && !empty[rr_next(last, k)]) begin
                gnt_any = 1'b1;
                gnt_src = rr_next(last, k);
            end
        end
        if (gnt_any) grant[gnt_src] = 1'b1;
    end

    assign head_addr = mem_addr[gnt_src][rd_ptr[gnt_src]];
    assign head_data = mem_data[gnt_src][rd_ptr[gnt_src]];

    // Registered write port; A3/WD hold when nothing is granted.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            we   <= 1'b0;
            A3   <= '0;
            WD   <= '0;
            last <= 2'd2;
        end else begin
            we <= gnt_any;
            if (gnt_any) begin
                A3   <= head_addr;
                WD   <= head_data;
                last <= gnt_src;
            end
        end
    end

    assign idle = !we && (&empty);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed phases with random data, checked every cycle
// against a queue-based model of the arbiter.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          vld [3];
    logic [AW-1:0] adr [3];
    logic [DW-1:0] dat [3];
    logic          rdy0, rdy1, rdy2;
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic          idle;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .res(res),
        .s0_valid(vld[0]), .s0_ready(rdy0), .s0_addr(adr[0]), .s0_data(dat[0]),
        .s1_valid(vld[1]), .s1_ready(rdy1), .s1_addr(adr[1]), .s1_data(dat[1]),
        .s2_valid(vld[2]), .s2_ready(rdy2), .s2_addr(adr[2]), .s2_data(dat[2]),
        .we(we), .A3(a3), .WD(wd), .idle(idle)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        q [3][$];
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;
    logic          acc [3];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic logic dut_rdy(input int n);
        case (n)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) q[n].delete();
        m_last = 2;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, we, 0);
        check({tag, "_a3"}, a3, 0);
        check({tag, "_wd"}, wd, 0);
        check({tag, "_idle"}, idle, 1);
        for (int n = 0; n < 3; n++) check($sformatf("%s_ready%0d", tag, n), dut_rdy(n), 1);
    endtask

    // One clock: model grants from pre-edge queue contents, then enqueues accepted pushes.
    task automatic step();
        int   g;
        int   c;
        logic exp_r;
        logic exp_idle;
        entry_t e;
        for (int n = 0; n < 3; n++) begin
            exp_r = (q[n].size() < DEPTH);
            check($sformatf("s%0d_ready", n), dut_rdy(n), exp_r);
            acc[n] = vld[n] && exp_r;
        end
        g = -1;
        for (int k = 1; k <= 3; k++) begin
            c = (m_last + k) % 3;
            if (g < 0 && q[c].size() != 0) g = c;
        end
        if (g >= 0) begin
            e      = q[g].pop_front();
            m_we   = 1'b1;
            m_a3   = e.addr;
            m_wd   = e.data;
            m_last = g;
        end else begin
            m_we = 1'b0;
        end
        for (int n = 0; n < 3; n++)
            if (acc[n] && adr[n] != '0) q[n].push_back({adr[n], dat[n]});
        @(posedge clk);
        #1;
        exp_idle = !m_we && q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0;
        check("we", we, m_we);
        check("A3", a3, m_a3);
        check("WD", wd, m_wd);
        check("idle", idle, exp_idle);
    endtask

    initial begin
        int            rr_seq [$];
        int            rr_exp [6];
        int            n_block;
        logic [DW-1:0] prev7;
        logic          have7;

        rr_exp = '{1, 3, 5, 2, 4, 6};
        for (int n = 0; n < 3; n++) begin
            vld[n] = 1'b0;
            adr[n] = '0;
            dat[n] = '0;
            acc[n] = 1'b0;
        end
        model_reset();

        // Power-on reset and release: no write may follow.
        #7;
        check_reset_outputs("por");
        res = 1'b0;
        step();
        step();

        // Single write from source 0.
        vld[0] = 1'b1; adr[0] = 5; dat[0] = 32'hDEADBEEF;
        step();
        vld[0] = 1'b0;
        step();
        check("single_we", we, 1);
        check("single_a3", a3, 5);
        check("single_wd", wd, 32'hDEADBEEF);
        step();
        check("single_we_drop", we, 0);

        // Writes to x0 handshake but vanish.
        vld[1] = 1'b1; adr[1] = 0; dat[1] = 32'h1234;
        step();
        vld[1] = 1'b0;
        step();
        step();
        check("x0_idle", idle, 1);

        // Asynchronous reset mid-cycle with a write pending.
        vld[2] = 1'b1; adr[2] = 9; dat[2] = $urandom;
        step();
        vld[2] = 1'b0;
        step();
        #3;
        res = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        res = 1'b0;
        model_reset();
        step();

        // Round-robin: two entries per source pushed in the same cycles.
        for (int n = 0; n < 3; n++) begin
            vld[n] = 1'b1;
            adr[n] = AW'(2 * n + 1);
            dat[n] = $urandom;
        end
        step();
        if (we) rr_seq.push_back(int'(a3));
        for (int n = 0; n < 3; n++) begin
            adr[n] = AW'(2 * n + 2);
            dat[n] = $urandom;
        end
        step();
        if (we) rr_seq.push_back(int'(a3));
        for (int n = 0; n < 3; n++) vld[n] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (we) rr_seq.push_back(int'(a3));
        end
        check("rr_count", rr_seq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < rr_seq.size()) check($sformatf("rr_a3_%0d", i), rr_seq[i], rr_exp[i]);

        // Backpressure: s2 streams addr 7 with incrementing data against s0/s1 traffic.
        n_block = 0;
        have7   = 1'b0;
        prev7   = '0;
        vld[0] = 1'b1; vld[1] = 1'b1; vld[2] = 1'b1;
        adr[2] = 7;
        dat[2] = $urandom;
        for (int i = 0; i < 40; i++) begin
            adr[0] = AW'($urandom_range(8, 19));
            adr[1] = AW'($urandom_range(20, 31));
            dat[0] = $urandom;
            dat[1] = $urandom;
            if (!rdy2) n_block++;
            step();
            if (acc[2]) dat[2] = dat[2] + 1;
            if (we && a3 == 7) begin
                if (have7) check("bp_wd_incr", wd, prev7 + 1);
                prev7 = wd;
                have7 = 1'b1;
            end
        end
        check("bp_s2_throttled", n_block > 0, 1);
        check("bp_s2_seen", have7, 1);

        // Reset pulse with all FIFOs full: none of the queued data may surface.
        for (int n = 0; n < 3; n++) vld[n] = 1'b0;
        #3;
        res = 1'b1;
        #1;
        check_reset_outputs("midstream");
        @(posedge clk);
        #1;
        res = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();

        // Random traffic, including x0 writes, then drain.
        for (int i = 0; i < 200; i++) begin
            for (int n = 0; n < 3; n++) begin
                vld[n] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) adr[n] = '0;
                else adr[n] = AW'($urandom_range(1 + 10 * n, 10 + 10 * n));
                dat[n] = $urandom;
            end
            step();
        end
        for (int n = 0; n < 3; n++) vld[n] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("final_idle", idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
